// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM preamble path: step-mode encoding,
// address-generator FSM states and the default preamble length.
package ofdm_pkg;

    localparam logic [1:0] MODE_STEP1 = 2'b00;
    localparam logic [1:0] MODE_STEP2 = 2'b01;
    localparam logic [1:0] MODE_STEP4 = 2'b10;

    localparam int STEP_W         = 3;
    localparam int PREAMBLE_DEPTH = 1648;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The reserved mode code falls back to unit stride.
    function automatic logic [STEP_W-1:0] step_of(input logic [1:0] mode_code);
        logic [STEP_W-1:0] step_val;
        step_val = 3'd1;
        case (mode_code)
            MODE_STEP2: step_val = 3'd2;
            MODE_STEP4: step_val = 3'd4;
            default:    step_val = 3'd1;
        endcase
        return step_val;
    endfunction

endpackage

// File: rtl/step_wrap_counter.sv
// Modulo-DEPTH counter with a runtime step; wrap flags the value that
// returns the counter to zero on the next advance.
module step_wrap_counter #(
    parameter int WIDTH  = 11,
    parameter int DEPTH  = 1648,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic              wrap
);

    localparam logic [WIDTH:0] DEPTH_EXT = (WIDTH+1)'(DEPTH);

    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] count_reg;

    // One extra bit so that count+step reaching DEPTH == 2^WIDTH cannot alias to 0.
    assign step_ext = {{(WIDTH+1-STEP_W){1'b0}}, step};
    assign sum      = {1'b0, count_reg} + step_ext;
    assign wrap     = (sum == DEPTH_EXT);
    assign count    = count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (advance) begin
            count_reg <= wrap ? '0 : sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/preamble_addr_gen.sv
// Preamble ROM address generator: walks the ROM with a decimation step,
// repeats the walk rep_num times and flags the final beat with last/done.
module preamble_addr_gen
    import ofdm_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = PREAMBLE_DEPTH,
    parameter int REP_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [REP_WIDTH-1:0]  rep_num,
    input  logic                  en,
    input  logic                  ready_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  valid_count,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    state_t                  state_reg;
    state_t                  state_next;
    logic [STEP_W-1:0]       step_reg;
    logic [REP_WIDTH-1:0]    rep_r_reg;
    logic [REP_WIDTH-1:0]    rep_reg;
    logic [REP_WIDTH-1:0]    rep_final;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    cnt_wrap;
    logic                    accept;
    logic                    final_beat;
    logic                    cnt_clear;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    valid_reg;
    logic                    last_reg;
    logic                    done_reg;

    step_wrap_counter #(
        .WIDTH  (ADDR_WIDTH),
        .DEPTH  (DEPTH),
        .STEP_W (STEP_W)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .advance (accept),
        .step    (step_reg),
        .count   (cnt),
        .wrap    (cnt_wrap)
    );

    assign rep_final = rep_r_reg - REP_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // start wins over a coincident final beat, so a restart never retires.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (!start && final_beat) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        accept     = 1'b0;
        final_beat = 1'b0;
        cnt_clear  = 1'b1;
        if (state_reg == ST_RUN) begin
            accept     = en && ready_in && !start;
            final_beat = accept && cnt_wrap && (rep_reg == rep_final);
            cnt_clear  = start;
        end
    end

    // Configuration is only captured on start; mid-run changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_reg  <= STEP_W'(1);
            rep_r_reg <= REP_WIDTH'(1);
        end else if (start) begin
            step_reg  <= step_of(mode);
            rep_r_reg <= (rep_num == '0) ? REP_WIDTH'(1) : rep_num;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_reg <= '0;
        end else if (cnt_clear || final_beat) begin
            rep_reg <= '0;
        end else if (accept && cnt_wrap) begin
            rep_reg <= rep_reg + REP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            if (accept) addr_reg <= cnt;
            valid_reg <= accept;
            last_reg  <= final_beat;
            done_reg  <= final_beat;
        end
    end

    assign addr        = addr_reg;
    assign valid_count = valid_reg;
    assign last        = last_reg;
    assign done        = done_reg;
    assign busy        = (state_reg == ST_RUN);

endmodule
